// File: rtl/mem_op_seq.sv
// rtl/mem_op_seq.sv - memory operation sequencer: one burst command per transfer, one outstanding
module mem_op_seq #(
  parameter int ADDR_W    = 32,
  parameter int BURST_W   = 20,
  parameter int ADDR_STEP = 64
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  input  logic               mem_init_i,
  input  logic               mem_test_i,
  input  logic               fifo_write_mem_i,
  input  logic               fifo_read_mem_i,
  input  logic               abort_i,
  input  logic [ADDR_W-1:0]  start_addr_i,
  input  logic [BURST_W-1:0] burst_cnt_i,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic [ADDR_W-1:0]  cmd_addr_o,
  output logic [1:0]         cmd_op_o,
  input  logic               resp_valid_i,
  input  logic               cmp_err_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               aborted_o,
  output logic [15:0]        err_cnt_o,
  output logic [BURST_W-1:0] bursts_done_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t             state, state_nxt;
  logic [BURST_W-1:0] cnt;
  logic               abort_pend;
  logic               start_any;
  logic [1:0]         start_op;
  logic               resp_hit;
  logic               abort_eff;
  logic               last_resp;

  assign start_any = mem_init_i | mem_test_i | fifo_write_mem_i | fifo_read_mem_i;

  always_comb begin
    start_op = 2'b11;
    if (mem_init_i)            start_op = 2'b00;
    else if (mem_test_i)       start_op = 2'b01;
    else if (fifo_write_mem_i) start_op = 2'b10;
  end

  // An abort arriving in the same cycle as a response still ends the job there.
  assign abort_eff = abort_pend | abort_i;
  assign resp_hit  = (state == WAIT_RESP) && resp_valid_i;
  assign last_resp = resp_hit && (((bursts_done_o + BURST_W'(1)) == cnt) || abort_eff);

  assign busy_o      = (state != IDLE);
  assign cmd_valid_o = (state == ISSUE);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_any && (burst_cnt_i != '0)) state_nxt = ISSUE;
      ISSUE:     if (cmd_ready_i) state_nxt = WAIT_RESP;
      WAIT_RESP: if (resp_valid_i) state_nxt = last_resp ? IDLE : ISSUE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cmd_addr_o    <= '0;
      cmd_op_o      <= 2'b00;
      cnt           <= '0;
      done_o        <= 1'b0;
      aborted_o     <= 1'b0;
      err_cnt_o     <= 16'd0;
      bursts_done_o <= '0;
      abort_pend    <= 1'b0;
    end else if ((state == IDLE) && start_any) begin
      cmd_addr_o    <= start_addr_i;
      cmd_op_o      <= start_op;
      cnt           <= burst_cnt_i;
      done_o        <= (burst_cnt_i == '0);
      aborted_o     <= 1'b0;
      err_cnt_o     <= 16'd0;
      bursts_done_o <= '0;
      abort_pend    <= 1'b0;
    end else begin
      if (busy_o && abort_i) abort_pend <= 1'b1;
      if (busy_o && (cmd_op_o == 2'b01) && cmp_err_i && (err_cnt_o != 16'hFFFF))
        err_cnt_o <= err_cnt_o + 16'd1;
      if (resp_hit) begin
        bursts_done_o <= bursts_done_o + BURST_W'(1);
        if (last_resp) begin
          done_o    <= 1'b1;
          aborted_o <= abort_eff;
        end else begin
          cmd_addr_o <= cmd_addr_o + ADDR_W'(ADDR_STEP);
        end
      end
    end
  end

endmodule
